instr_wb_arbiter: RTL and testbench

- Two-master to one-slave pipelined Wishbone arbiter for the test library.
- Lets two bench masters (e.g. instruction-fetch and load/store models) share one instrumented Wishbone slave.
- Round-robin grant, held for the whole bus cycle (cyc high), with registered grant decisions.
- Routes stb/adr/dat/we/sel forward and ack/dat/stall back to the granted master only.

---
 rtl/instr_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_instr_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_wb_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter with round-robin, registered grant.
// Optional watchdog that drops a stuck grant: define INSTR_WB_ARBITER_TIMEOUT_EN.
module instr_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_stall_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_stall_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_stall_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT0 = 2'b01;
    localparam logic [1:0] GRANT1 = 2'b10;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       wd_expire;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("instr_wb_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches inferred.
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0:  if (!m0_cyc_i) state_d = IDLE;
            GRANT1:  if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A watchdog drop leaves last_q alone so the other master wins the next tie.
        if (wd_expire) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments for all registered state.
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        case (state_q)
            GRANT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_stb_o = m0_stb_i;
                s_cyc_o = m0_cyc_i;
            end
            GRANT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_stb_o = m1_stb_i;
                s_cyc_o = m1_cyc_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the ack tells a master it is meant for it.
    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;
    assign m0_ack_o   = (state_q == GRANT0) && s_ack_i;
    assign m1_ack_o   = (state_q == GRANT1) && s_ack_i;
    assign m0_stall_o = (state_q == GRANT0) ? s_stall_i : 1'b1;
    assign m1_stall_o = (state_q == GRANT1) ? s_stall_i : 1'b1;
    assign grant_o    = state_q;

`ifdef INSTR_WB_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_q;
    logic        timeout_q;
    logic        wd_inc;

    assign wd_inc    = (state_q != IDLE) && s_cyc_o && !s_ack_i;
    assign wd_expire = wd_inc && ((wd_q + 16'd1) == TIMEOUT_LIMIT);

    // Counter idles at zero outside a grant, so every new grant starts from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state_q == IDLE || s_ack_i || wd_expire) begin
                wd_q <= '0;
            end else if (wd_inc) begin
                wd_q <= wd_q + 16'd1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_wb_arbiter.sv
// Self-checking bench for instr_wb_arbiter: a per-cycle vector table plus directed
// multi-cycle sequences (tie-break, no preemption, slave stall, reset, watchdog).
module tb_instr_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_stall_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    instr_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_stall_o(m0_stall_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_stall_o(m1_stall_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_stall_i(s_stall_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       m0c, m0s, m1c, m1s, ack, stall;
        logic [1:0] g;
        logic       scyc, sstb, m0a, m1a, m0st, m1st;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled well after the edge.
    task automatic next();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set(input logic m0c, m0s, m1c, m1s, ack, stall);
        m0_cyc_i = m0c; m0_stb_i = m0s;
        m1_cyc_i = m1c; m1_stb_i = m1s;
        s_ack_i  = ack; s_stall_i = stall;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set(0, 0, 0, 0, 0, 0);
        next();
        next();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_i    = 1'b1;
        m0_adr_i = 32'h0000_0100; m0_dat_i = 32'hA0A0_0000; m0_we_i = 1'b1; m0_sel_i = 4'hF;
        m1_adr_i = 32'h0000_0200; m1_dat_i = 32'hB1B1_1111; m1_we_i = 1'b0; m1_sel_i = 4'h3;
        s_dat_i  = 32'h5A5A_0001;
        set(0, 0, 0, 0, 0, 1);

        //          m0c m0s m1c m1s ack stl  g      scyc sstb m0a m1a m0st m1st
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 1, 0, 2'b01, 1, 0, 1, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{1, 1, 1, 1, 0, 1, 2'b10, 1, 1, 0, 0, 1, 1};
        tbl[8]  = '{1, 1, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{1, 1, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1};
        tbl[12] = '{1, 1, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1};

        // Reset state, sampled while reset is still held.
        next();
        next();
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_scyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'h0);
        check("rst_fwd", s_adr_o | s_dat_o | {27'd0, s_we_o, s_sel_o}, 32'h0);
        check("rst_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'h0);
        check("rst_stalls", {30'd0, m0_stall_o, m1_stall_o}, 32'h3);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        check("rst_m0_dat", m0_dat_o, 32'h5A5A_0001);
        rst_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            logic [31:0] e_adr, e_dat;
            logic [4:0]  e_wsel;
            next();
            s_dat_i = 32'hD000_0000 + 32'(i);
            set(tbl[i].m0c, tbl[i].m0s, tbl[i].m1c, tbl[i].m1s, tbl[i].ack, tbl[i].stall);
            e_adr  = (tbl[i].g == 2'b01) ? 32'h0000_0100 : (tbl[i].g == 2'b10) ? 32'h0000_0200 : 32'h0;
            e_dat  = (tbl[i].g == 2'b01) ? 32'hA0A0_0000 : (tbl[i].g == 2'b10) ? 32'hB1B1_1111 : 32'h0;
            e_wsel = (tbl[i].g == 2'b01) ? 5'h1F : (tbl[i].g == 2'b10) ? 5'h03 : 5'h00;
            check($sformatf("v%0d_grant", i), 32'(grant_o), 32'(tbl[i].g));
            check($sformatf("v%0d_scyc_stb", i), {30'd0, s_cyc_o, s_stb_o}, {30'd0, tbl[i].scyc, tbl[i].sstb});
            check($sformatf("v%0d_adr", i), s_adr_o, e_adr);
            check($sformatf("v%0d_wdat", i), s_dat_o, e_dat);
            check($sformatf("v%0d_we_sel", i), {27'd0, s_we_o, s_sel_o}, {27'd0, e_wsel});
            check($sformatf("v%0d_acks", i), {30'd0, m0_ack_o, m1_ack_o}, {30'd0, tbl[i].m0a, tbl[i].m1a});
            check($sformatf("v%0d_stalls", i), {30'd0, m0_stall_o, m1_stall_o}, {30'd0, tbl[i].m0st, tbl[i].m1st});
            check($sformatf("v%0d_rdat", i), m0_dat_o ^ m1_dat_o ^ m0_dat_o, 32'hD000_0000 + 32'(i));
        end

        // Simultaneous requests after reset: m0 first, one idle cycle, then m1, then m0 again.
        do_reset();
        set(1, 1, 1, 1, 0, 0);
        next();
        check("tie_first_m0", 32'(grant_o), 32'h1);
        set(0, 0, 1, 1, 0, 0);
        next();
        check("tie_gap_idle", 32'(grant_o), 32'h0);
        next();
        check("tie_then_m1", 32'(grant_o), 32'h2);
        set(0, 0, 0, 0, 0, 0);
        next();
        check("tie_release", 32'(grant_o), 32'h0);
        set(1, 1, 1, 1, 0, 0);
        next();
        check("tie_second_m0", 32'(grant_o), 32'h1);
        set(0, 0, 0, 0, 0, 0);
        next();

        // m1 waits for 5 cycles of m0 ownership without preempting it.
        set(1, 1, 0, 0, 0, 0);
        next();
        set(1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_grant", k), 32'(grant_o), 32'h1);
            check($sformatf("hold%0d_m1_stall", k), 32'(m1_stall_o), 32'h1);
            next();
        end
        set(0, 0, 1, 1, 0, 0);
        next();
        check("hold_idle", 32'(grant_o), 32'h0);
        check("hold_idle_m1_stall", 32'(m1_stall_o), 32'h1);
        next();
        check("hold_m1_granted", 32'(grant_o), 32'h2);
        check("hold_m1_adr", s_adr_o, 32'h0000_0200);
        set(0, 0, 0, 0, 0, 0);
        next();

        // Slave stall during an m0 grant is mirrored to m0 only; address stays with m0.
        set(1, 1, 0, 0, 0, 0);
        next();
        for (int k = 0; k < 3; k++) begin
            set(1, 1, 1, 1, 0, 1);
            check($sformatf("sstall%0d_m0", k), 32'(m0_stall_o), 32'h1);
            check($sformatf("sstall%0d_m1", k), 32'(m1_stall_o), 32'h1);
            check($sformatf("sstall%0d_adr", k), s_adr_o, 32'h0000_0100);
            next();
        end
        set(1, 1, 1, 1, 0, 0);
        check("sstall_release_m0", 32'(m0_stall_o), 32'h0);
        check("sstall_release_m1", 32'(m1_stall_o), 32'h1);
        set(0, 0, 0, 0, 0, 0);
        next();
        next();

        // Reset while m1 owns the bus with an access outstanding.
        set(0, 0, 1, 1, 0, 0);
        next();
        check("rstmid_pre_grant", 32'(grant_o), 32'h2);
        rst_i = 1'b1;
        next();
        check("rstmid_grant", 32'(grant_o), 32'h0);
        check("rstmid_scyc", 32'(s_cyc_o), 32'h0);
        set(0, 0, 1, 1, 1, 0);
        check("rstmid_late_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'h0);
        rst_i = 1'b0;
        set(0, 0, 0, 0, 0, 0);
        next();
        set(1, 1, 1, 1, 0, 0);
        next();
        check("rstmid_last_is_1", 32'(grant_o), 32'h1);
        set(0, 0, 0, 0, 0, 0);
        next();
        next();

        // Slave never acks an m0 access while m1 waits.
        set(1, 1, 0, 0, 0, 0);
        next();
        set(1, 1, 1, 1, 0, 0);
`ifdef INSTR_WB_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wd%0d_grant", k), 32'(grant_o), 32'h1);
            check($sformatf("wd%0d_timeout", k), 32'(timeout_o), 32'h0);
            next();
        end
        check("wd_expire_grant", 32'(grant_o), 32'h0);
        check("wd_expire_pulse", 32'(timeout_o), 32'h1);
        next();
        check("wd_m1_next", 32'(grant_o), 32'h2);
        check("wd_pulse_end", 32'(timeout_o), 32'h0);
`else
        for (int k = 0; k < 20; k++) begin
            next();
            if (timeout_o !== 1'b0 || grant_o !== 2'b01) begin
                check($sformatf("nowd%0d_grant_timeout", k), {29'd0, grant_o, timeout_o}, 32'h2);
            end
        end
        check("nowd_grant_held", 32'(grant_o), 32'h1);
        check("nowd_timeout_low", 32'(timeout_o), 32'h0);
`endif
        set(0, 0, 0, 0, 0, 0);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
